// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: instruction fetch sequencer.
// Owns the program counter and drives the instruction memory read address.
// Each instruction and its PC are registered into a one-entry output stage
// that decode drains with a valid/ready handshake. The block also handles
// start/stop, control-flow redirects, and alignment/range faults.
// RESET_PC must be 4-byte aligned and below (4 << MEM_DEPTH_POW), and
// MEM_DEPTH_POW + 3 must not exceed ADDR_WIDTH.
module instr_fetch_ctrl #(
  parameter int                    ADDR_WIDTH    = 64,
  parameter int                    MEM_DEPTH_POW = 10,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC      = '0
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  enable_in,
  input  logic                  redirect_valid_in,
  input  logic [ADDR_WIDTH-1:0] redirect_pc_in,
  output logic [ADDR_WIDTH-1:0] imem_addr_out,
  input  logic [31:0]           imem_instr_in,
  output logic                  out_valid_out,
  input  logic                  out_ready_in,
  output logic [31:0]           out_instr_out,
  output logic [ADDR_WIDTH-1:0] out_pc_out,
  output logic                  fault_out,
  output logic [1:0]            fault_cause_out,
  output logic [ADDR_WIDTH-1:0] fault_pc_out
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_FAULT
  } state_t;

  localparam logic [1:0] CAUSE_MISALIGN = 2'b01;
  localparam logic [1:0] CAUSE_RANGE    = 2'b10;

  // First byte address past the end of instruction memory.
  localparam logic [ADDR_WIDTH-1:0] PC_LIMIT =
    {{(ADDR_WIDTH-3){1'b0}}, 3'b100} << MEM_DEPTH_POW;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] pc_q;

  logic handshake;
  logic stage_free;
  logic pc_in_range;
  logic redirect_aligned;

  // The memory is read at the current PC; this is the only combinational output.
  assign imem_addr_out = pc_q;

  // Decode consumes the held instruction, leaving room for a new capture.
  assign handshake        = out_valid_out & out_ready_in;
  assign stage_free       = ~out_valid_out | handshake;
  // Checked before any capture, so the PC never wraps past the top of memory.
  assign pc_in_range      = (pc_q < PC_LIMIT);
  assign redirect_aligned = (redirect_pc_in[1:0] == 2'b00);

  // Fetch state machine with registered output stage and fault reporting.
  // NOTE: all state here uses non-blocking assignments so every register
  // samples the pre-edge values; blocking would chain updates within a cycle.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q         <= ST_IDLE;
      pc_q            <= RESET_PC;
      out_valid_out   <= 1'b0;
      out_instr_out   <= '0;
      out_pc_out      <= '0;
      fault_out       <= 1'b0;
      fault_cause_out <= 2'b00;
      fault_pc_out    <= '0;
    end else begin
      case (state_q)
        ST_FAULT: begin
          // Terminal until reset: nothing moves, output stage stays empty.
          out_valid_out <= 1'b0;
        end

        default: begin
          if (redirect_valid_in) begin
            // Flush whatever is held; a simultaneous handshake already took it.
            out_valid_out <= 1'b0;
            if (redirect_aligned) begin
              pc_q <= redirect_pc_in;
            end else begin
              state_q         <= ST_FAULT;
              fault_out       <= 1'b1;
              fault_cause_out <= CAUSE_MISALIGN;
              fault_pc_out    <= redirect_pc_in;
            end
          end else if (state_q == ST_RUN && stage_free && !pc_in_range) begin
            // Ran off the end of memory: report the PC that would have been fetched.
            state_q         <= ST_FAULT;
            out_valid_out   <= 1'b0;
            fault_out       <= 1'b1;
            fault_cause_out <= CAUSE_RANGE;
            fault_pc_out    <= pc_q;
          end else begin
            if (state_q == ST_RUN && stage_free) begin
              out_instr_out <= imem_instr_in;
              out_pc_out    <= pc_q;
              out_valid_out <= 1'b1;
              pc_q          <= pc_q + ADDR_WIDTH'(4);
            end else if (handshake) begin
              out_valid_out <= 1'b0;
            end
            state_q <= enable_in ? ST_RUN : ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: two instances (full-size memory and a 4-word
// memory) share stimulus. A behavioural model of the fetch stream is stepped
// each clock and compared against both; directed sequences cover start-up,
// backpressure, redirects, faults and asynchronous reset, then random traffic.
module tb_instr_fetch_ctrl;

  localparam int AW = 64;

  logic          clk            = 1'b0;
  logic          rst_n          = 1'b0;
  logic          enable         = 1'b0;
  logic          redirect_valid = 1'b0;
  logic [AW-1:0] redirect_pc    = '0;
  logic          out_ready      = 1'b0;

  logic [1:0][AW-1:0] imem_addr;
  logic [1:0][31:0]   imem_instr;
  logic [1:0]         out_valid;
  logic [1:0][31:0]   out_instr;
  logic [1:0][AW-1:0] out_pc;
  logic [1:0]         fault;
  logic [1:0][1:0]    fault_cause;
  logic [1:0][AW-1:0] fault_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory contents: word k holds value k.
  assign imem_instr[0] = imem_addr[0][33:2];
  assign imem_instr[1] = imem_addr[1][33:2];

  instr_fetch_ctrl #(.ADDR_WIDTH(AW), .MEM_DEPTH_POW(10), .RESET_PC('0)) dut_big (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(enable),
    .redirect_valid_in(redirect_valid), .redirect_pc_in(redirect_pc),
    .imem_addr_out(imem_addr[0]), .imem_instr_in(imem_instr[0]),
    .out_valid_out(out_valid[0]), .out_ready_in(out_ready),
    .out_instr_out(out_instr[0]), .out_pc_out(out_pc[0]),
    .fault_out(fault[0]), .fault_cause_out(fault_cause[0]), .fault_pc_out(fault_pc[0])
  );

  instr_fetch_ctrl #(.ADDR_WIDTH(AW), .MEM_DEPTH_POW(2), .RESET_PC('0)) dut_small (
    .clk_in(clk), .rst_n_in(rst_n), .enable_in(enable),
    .redirect_valid_in(redirect_valid), .redirect_pc_in(redirect_pc),
    .imem_addr_out(imem_addr[1]), .imem_instr_in(imem_instr[1]),
    .out_valid_out(out_valid[1]), .out_ready_in(out_ready),
    .out_instr_out(out_instr[1]), .out_pc_out(out_pc[1]),
    .fault_out(fault[1]), .fault_cause_out(fault_cause[1]), .fault_pc_out(fault_pc[1])
  );

  // Behavioural view: fetching or not, faulted or not, next PC, held slot.
  typedef struct {
    bit            fetching;
    bit            faulted;
    bit            held;
    logic [AW-1:0] next_pc;
    logic [31:0]   held_instr;
    logic [AW-1:0] held_pc;
    logic [1:0]    cause;
    logic [AW-1:0] bad_pc;
  } model_t;

  model_t m[2];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m[i].fetching   = 0;
      m[i].faulted    = 0;
      m[i].held       = 0;
      m[i].next_pc    = '0;
      m[i].held_instr = '0;
      m[i].held_pc    = '0;
      m[i].cause      = 2'b00;
      m[i].bad_pc     = '0;
    end
  endtask

  // One clock of the fetch rules, using the inputs presented during that cycle.
  task automatic model_step(input int i);
    logic [AW-1:0] mem_bytes;
    bit consumed;
    mem_bytes = (i == 0) ? 64'd4096 : 64'd16;
    if (m[i].faulted) return;
    consumed = m[i].held && out_ready;
    if (redirect_valid) begin
      m[i].held = 0;
      if (redirect_pc % 4 == 0) begin
        m[i].next_pc = redirect_pc;
      end else begin
        m[i].faulted = 1;
        m[i].cause   = 2'b01;
        m[i].bad_pc  = redirect_pc;
      end
      return;
    end
    if (consumed) m[i].held = 0;
    if (m[i].fetching && !m[i].held) begin
      if (m[i].next_pc < mem_bytes) begin
        m[i].held       = 1;
        m[i].held_pc    = m[i].next_pc;
        m[i].held_instr = 32'(m[i].next_pc / 4);
        m[i].next_pc    = m[i].next_pc + 4;
      end else begin
        m[i].faulted = 1;
        m[i].cause   = 2'b10;
        m[i].bad_pc  = m[i].next_pc;
        return;
      end
    end
    m[i].fetching = enable;
  endtask

  task automatic compare_all();
    string p;
    for (int i = 0; i < 2; i++) begin
      p = (i == 0) ? "big" : "small";
      check({p, " valid"}, 64'(out_valid[i]), 64'(m[i].held && !m[i].faulted));
      if (m[i].held && !m[i].faulted) begin
        check({p, " out_pc"}, out_pc[i], m[i].held_pc);
        check({p, " out_instr"}, 64'(out_instr[i]), 64'(m[i].held_instr));
      end
      check({p, " fault"}, 64'(fault[i]), 64'(m[i].faulted));
      check({p, " cause"}, 64'(fault_cause[i]), 64'(m[i].cause));
      check({p, " fault_pc"}, fault_pc[i], m[i].bad_pc);
      check({p, " imem_addr"}, imem_addr[i], m[i].next_pc);
    end
  endtask

  // Advance one clock: model follows the edge, outputs compared mid-cycle.
  task automatic cycle();
    @(posedge clk);
    for (int i = 0; i < 2; i++) model_step(i);
    @(negedge clk);
    compare_all();
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      check("reset valid", 64'(out_valid[i]), 64'd0);
      check("reset out_instr", 64'(out_instr[i]), 64'd0);
      check("reset out_pc", out_pc[i], 64'd0);
      check("reset fault", 64'(fault[i]), 64'd0);
      check("reset imem_addr", imem_addr[i], 64'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    @(negedge clk);
    do_reset();

    // Start-up: enable in cycle 0, RUN in cycle 1, first valid in cycle 2.
    enable = 1'b1; out_ready = 1'b1;
    cycle();
    check("startup no valid yet", 64'(out_valid[0]), 64'd0);
    out_ready = 1'b0;
    cycle();
    check("first valid", 64'(out_valid[0]), 64'd1);
    check("first pc", out_pc[0], 64'd0);
    check("first instr", 64'(out_instr[0]), 64'd0);

    // Backpressure for three cycles: the held instruction stays put.
    repeat (3) begin
      cycle();
      check("stall valid", 64'(out_valid[0]), 64'd1);
      check("stall pc", out_pc[0], 64'd0);
      check("stall imem_addr", imem_addr[0], 64'd4);
    end
    out_ready = 1'b1;
    cycle();
    check("resume pc", out_pc[0], 64'd4);
    check("resume instr", 64'(out_instr[0]), 64'd1);
    cycle();
    cycle();
    check("stream pc 12", out_pc[0], 64'd12);
    check("stream instr 3", 64'(out_instr[0]), 64'd3);
    cycle();
    check("stream pc 16", out_pc[0], 64'd16);
    // Four-word memory delivered 0,4,8,12 and then ran out of range.
    check("small range fault", 64'(fault[1]), 64'd1);
    check("small range cause", 64'(fault_cause[1]), 64'd2);
    check("small range fault_pc", fault_pc[1], 64'd16);
    check("small valid after fault", 64'(out_valid[1]), 64'd0);

    // Redirect while a valid instruction is held and being accepted.
    redirect_valid = 1'b1; redirect_pc = 64'h40;
    cycle();
    redirect_valid = 1'b0;
    check("redirect flush", 64'(out_valid[0]), 64'd0);
    check("redirect imem_addr", imem_addr[0], 64'h40);
    cycle();
    check("redirect target valid", 64'(out_valid[0]), 64'd1);
    check("redirect target pc", out_pc[0], 64'h40);
    check("redirect target instr", 64'(out_instr[0]), 64'd16);

    // Misaligned redirect faults; a later redirect is ignored.
    redirect_valid = 1'b1; redirect_pc = 64'h42;
    cycle();
    check("misalign fault", 64'(fault[0]), 64'd1);
    check("misalign cause", 64'(fault_cause[0]), 64'd1);
    check("misalign fault_pc", fault_pc[0], 64'h42);
    redirect_pc = 64'h0;
    cycle();
    redirect_valid = 1'b0;
    check("fault ignores redirect", imem_addr[0], 64'h44);
    check("fault holds valid low", 64'(out_valid[0]), 64'd0);
    check("fault sticky cause", 64'(fault_cause[0]), 64'd1);

    // Reset mid-stream with a valid instruction held, then restart.
    do_reset();
    cycle();
    cycle();
    cycle();
    check("pre-reset valid", 64'(out_valid[0]), 64'd1);
    do_reset();
    cycle();
    cycle();
    check("restart valid", 64'(out_valid[0]), 64'd1);
    check("restart pc", out_pc[0], 64'd0);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      enable         = ($urandom_range(0, 9) != 0);
      out_ready      = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 19) == 0);
      case ($urandom_range(0, 9))
        0:       redirect_pc = 64'($urandom_range(0, 64)) * 64'd4 + 64'($urandom_range(1, 3));
        1, 2:    redirect_pc = 64'($urandom_range(0, 3)) * 64'd4;
        3, 4:    redirect_pc = 64'($urandom_range(1016, 1030)) * 64'd4;
        5:       redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
        default: redirect_pc = 64'($urandom_range(0, 1023)) * 64'd4;
      endcase
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_ctrl.md
# instr_fetch_ctrl

Sequencer for the instruction memory. It owns the program counter, drives the memory read address, and registers each returned instruction with its PC into a one-entry output stage with a valid/ready handshake toward decode. It also handles start/stop, control-flow redirects, and alignment/range faults, and sits between the instruction memory and the decode stage.

## Interface
- ADDR_WIDTH, 64: PC and memory address width in bits.
- MEM_DEPTH_POW, 10: log2 of instruction memory depth in words; fetchable byte range is 0 .. (4 << MEM_DEPTH_POW) - 1.
- RESET_PC, 0: PC loaded at reset. Must be 4-byte aligned and in range (elaboration-time constraint).

- clk_in  input  1  single clock, rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- enable_in  input  1  level; 1 = fetch, 0 = stop fetching.
- redirect_valid_in  input  1  one-cycle pulse: load redirect_pc_in and flush.
- redirect_pc_in  input  ADDR_WIDTH  redirect target.
- imem_addr_out  output  ADDR_WIDTH  read address to the instruction memory; equals pc_q, purely combinational.
- imem_instr_in  input  32  combinational read data returned for imem_addr_out.
- out_valid_out  output  1  output stage holds an instruction.
- out_ready_in  input  1  decode accepts the instruction this cycle.
- out_instr_out  output  32  registered instruction.
- out_pc_out  output  ADDR_WIDTH  PC of out_instr_out.
- fault_out  output  1  sticky fault flag.
- fault_cause_out  output  2  01 = misaligned redirect, 10 = PC out of range, 00 = none.
- fault_pc_out  output  ADDR_WIDTH  offending PC.

## Operation
- States:
  - IDLE (reset state).
  - RUN.
  - FAULT (terminal until reset).
- Reset values: state IDLE, pc_q = RESET_PC, and all outputs 0 except imem_addr_out, which equals RESET_PC.
- A handshake fires when out_valid_out and out_ready_in are both 1.
- Output stage is "free" when out_valid_out = 0 or a handshake fires this cycle.
- IDLE -> RUN when enable_in = 1. RUN -> IDLE when enable_in = 0.
  - In IDLE, no new captures occur.
  - A held output stays valid until handshaked.
- In RUN, with no redirect, when the stage is free and pc_q is in range:
  - Capture out_instr_out <= imem_instr_in, out_pc_out <= pc_q, out_valid_out <= 1.
  - Then pc_q <= pc_q + 4.
- In RUN, when the stage is free but pc_q >= (4 << MEM_DEPTH_POW):
  - No capture.
  - State -> FAULT, cause 10, fault_pc_out <= pc_q.
- In RUN, when the stage is not free, pc_q and the output stage hold their values.
- If a handshake fires and no capture occurs, out_valid_out <= 0.
- Redirect (IDLE or RUN) has priority over capture and fault checks:
  - Flush: out_valid_out <= 0. A simultaneous handshake still counts as consumed.
  - No capture that cycle.
  - If redirect_pc_in[1:0] = 0: pc_q <= redirect_pc_in; state is unchanged.
  - Otherwise: state -> FAULT, cause 01, fault_pc_out <= redirect_pc_in, and pc_q is unchanged.
- In FAULT:
  - out_valid_out = 0 and fault_out = 1.
  - Redirect and enable are ignored; pc_q holds.
  - Only reset exits FAULT.
- PC arithmetic is modulo 2^ADDR_WIDTH. The range check fires before any wrap is observable.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronous), discarding any held instruction.

## Timing
- Start: enable_in goes 1 in cycle 0 -> RUN in cycle 1 -> first instruction valid in cycle 2 with out_pc_out = RESET_PC.
- Throughput: one instruction per cycle while out_ready_in = 1 and the PC is in range. PCs step by 4 per cycle.
- Backpressure: while out_ready_in = 0, outputs and pc_q are stable.
- Redirect pulse in cycle N:
  - out_valid_out = 0 in cycle N+1.
  - imem_addr_out = target in cycle N+1.
  - Target instruction valid in cycle N+2.
- Fault is visible on fault_out in the cycle after detection.
- No combinational path from any input to out_* or fault_*. Only imem_addr_out is combinational, and only from pc_q.

## Test plan
- Reset then enable with RESET_PC = 0 and out_ready_in = 1, memory word k = k: out_valid_out rises in cycle 2. Pairs (pc, instr) = (0,0), (4,1), (8,2), ... one per cycle.
- Hold out_ready_in = 0 for 3 cycles after the first valid: out_instr_out = 0 and out_pc_out = 0 stay stable. Releasing ready resumes with pc 4 and no skipped or duplicated instruction.
- Redirect to 0x40 while a valid is held and out_ready_in = 1: out_valid_out = 0 in the next cycle. The next valid has out_pc_out = 0x40 and instr = 16. The held instruction counts as consumed exactly once.
- Redirect to 0x42: fault_out = 1, fault_cause_out = 01, fault_pc_out = 0x42, out_valid_out stays 0. A later redirect to 0x0 is ignored.
- MEM_DEPTH_POW = 2 with continuous fetch: pcs 0, 4, 8, 12 are delivered. Then FAULT with cause 10 and fault_pc_out = 16.
- Assert rst_n_in mid-stream with out_valid_out = 1: all outputs are 0 immediately and imem_addr_out = RESET_PC. Fetch restarts from RESET_PC after deassertion.
